// File: rtl/alu_seq.sv
// LC-3b operate-instruction sequencer: reads operands over one register-file
// port, drives the external ALU, writes the result back and updates N/Z/P.
module alu_seq (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  output logic [2:0]  rf_raddr,
  input  logic [15:0] rf_rdata,
  output logic [15:0] alu_in1,
  output logic [15:0] alu_in2,
  output logic [2:0]  alu_op,
  output logic [3:0]  alu_shift,
  input  logic [15:0] alu_out,
  output logic        rf_we,
  output logic [2:0]  rf_waddr,
  output logic [15:0] rf_wdata,
  output logic        cc_n,
  output logic        cc_z,
  output logic        cc_p,
  output logic        done,
  output logic        illegal
);

  typedef enum logic [2:0] {IDLE, RD1, RD2, EXEC, WB, ERR} state_t;

  state_t      state_q;
  logic [2:0]  dr_q;
  logic [2:0]  sr2_q;
  logic [4:0]  imm5_q;
  logic        reg_mode_q;
  logic        shf_q;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [15:0] res_q;
  logic [2:0]  op_q;
  logic [3:0]  shift_q;
  logic [2:0]  raddr_q;
  logic        we_q;
  logic        done_q;
  logic        illegal_q;
  logic [2:0]  cc_q;

  logic        dec_legal;
  logic        dec_shf;
  logic [2:0]  dec_op;
  logic [3:0]  dec_shift;
  logic        dec_reg_mode;

  always_comb begin
    dec_legal = 1'b0;
    dec_shf   = 1'b0;
    dec_op    = 3'd0;
    case (instr[15:12])
      4'b0001: begin dec_legal = 1'b1; dec_op = 3'd0; end
      4'b0101: begin dec_legal = 1'b1; dec_op = 3'd1; end
      4'b1001: begin dec_legal = 1'b1; dec_op = 3'd3; end
      4'b1101: begin
        dec_legal = 1'b1;
        dec_shf   = 1'b1;
        case (instr[5:4])
          2'b00:   dec_op = 3'd4;
          2'b01:   dec_op = 3'd5;
          2'b11:   dec_op = 3'd6;
          default: dec_op = 3'd7;
        endcase
      end
      default: dec_legal = 1'b0;
    endcase
    dec_shift    = dec_shf ? instr[3:0] : 4'd0;
    dec_reg_mode = dec_legal && !dec_shf && !instr[5];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      dr_q       <= 3'd0;
      sr2_q      <= 3'd0;
      imm5_q     <= 5'd0;
      reg_mode_q <= 1'b0;
      shf_q      <= 1'b0;
      a_q        <= 16'd0;
      b_q        <= 16'd0;
      res_q      <= 16'd0;
      op_q       <= 3'd0;
      shift_q    <= 4'd0;
      raddr_q    <= 3'd0;
      we_q       <= 1'b0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
      cc_q       <= 3'b010;
    end else begin
      we_q      <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      case (state_q)
        IDLE: if (instr_valid) begin
          if (dec_legal) begin
            dr_q       <= instr[11:9];
            sr2_q      <= instr[2:0];
            imm5_q     <= instr[4:0];
            reg_mode_q <= dec_reg_mode;
            shf_q      <= dec_shf;
            op_q       <= dec_op;
            shift_q    <= dec_shift;
            raddr_q    <= instr[8:6];
            state_q    <= RD1;
          end else begin
            illegal_q <= 1'b1;
            state_q   <= ERR;
          end
        end
        RD1: begin
          a_q <= rf_rdata;
          if (reg_mode_q) begin
            raddr_q <= sr2_q;
            state_q <= RD2;
          end else begin
            b_q     <= shf_q ? 16'd0 : {{11{imm5_q[4]}}, imm5_q};
            raddr_q <= 3'd0;
            state_q <= EXEC;
          end
        end
        RD2: begin
          b_q     <= rf_rdata;
          raddr_q <= 3'd0;
          state_q <= EXEC;
        end
        EXEC: begin
          res_q   <= alu_out;
          we_q    <= 1'b1;
          done_q  <= 1'b1;
          state_q <= WB;
        end
        // CC changes together with the register-file write landing
        WB: begin
          cc_q    <= {res_q[15], res_q == 16'd0, !res_q[15] && (res_q != 16'd0)};
          state_q <= IDLE;
        end
        ERR:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign instr_ready = (state_q == IDLE);
  assign rf_raddr    = raddr_q;
  assign alu_in1     = a_q;
  assign alu_in2     = b_q;
  assign alu_op      = op_q;
  assign alu_shift   = shift_q;
  assign rf_we       = we_q;
  assign rf_waddr    = dr_q;
  assign rf_wdata    = res_q;
  assign done        = done_q;
  assign illegal     = illegal_q;
  assign cc_n        = cc_q[2];
  assign cc_z        = cc_q[1];
  assign cc_p        = cc_q[0];

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: behavioural ALU and register file around the DUT, with a
// shadow register model computing expected results directly from the ISA.
module tb_alu_seq;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [2:0]  rf_raddr;
  logic [15:0] rf_rdata;
  logic [15:0] alu_in1, alu_in2;
  logic [2:0]  alu_op;
  logic [3:0]  alu_shift;
  logic [15:0] alu_out;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        cc_n, cc_z, cc_p, done, illegal;

  always #5 clk = ~clk;

  alu_seq dut (
    .clk(clk), .reset_n(reset_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .alu_in1(alu_in1),
    .alu_in2(alu_in2), .alu_op(alu_op), .alu_shift(alu_shift), .alu_out(alu_out),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .cc_n(cc_n), .cc_z(cc_z),
    .cc_p(cc_p), .done(done), .illegal(illegal)
  );

  always_comb begin
    case (alu_op)
      3'd0:    alu_out = alu_in1 + alu_in2;
      3'd1:    alu_out = alu_in1 & alu_in2;
      3'd2:    alu_out = ~alu_in1;
      3'd3:    alu_out = alu_in1 ^ alu_in2;
      3'd4:    alu_out = alu_in1 << alu_shift;
      3'd5:    alu_out = alu_in1 >> alu_shift;
      3'd6:    alu_out = 16'($signed(alu_in1) >>> alu_shift);
      default: alu_out = 16'd0;
    endcase
  end

  logic [15:0] rf [8];
  logic        pl_en;
  logic [2:0]  pl_addr;
  logic [15:0] pl_data;
  always_ff @(posedge clk) begin
    if (pl_en) rf[pl_addr] <= pl_data;
    else if (rf_we) rf[rf_waddr] <= rf_wdata;
  end
  assign rf_rdata = rf[rf_raddr];

  logic [15:0] mrf [8];
  logic [2:0]  exp_cc;
  int n_assert = 0;
  int n_fail = 0;
  logic [3:0] leg_tab [4] = '{4'h1, 4'h5, 4'h9, 4'hD};
  logic [3:0] ill_tab [12] = '{4'h0, 4'h2, 4'h3, 4'h4, 4'h6, 4'h7, 4'h8, 4'hA, 4'hB, 4'hC, 4'hE, 4'hF};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic is_legal(input logic [3:0] opc);
    return opc == 4'h1 || opc == 4'h5 || opc == 4'h9 || opc == 4'hD;
  endfunction

  function automatic logic [15:0] sext5(input logic [4:0] v);
    return {{11{v[4]}}, v};
  endfunction

  function automatic logic [15:0] exp_b(input logic [15:0] ins);
    if (ins[15:12] == 4'hD) return 16'd0;
    return ins[5] ? sext5(ins[4:0]) : mrf[ins[2:0]];
  endfunction

  function automatic logic [15:0] model(input logic [15:0] ins);
    logic [15:0] a, b;
    a = mrf[ins[8:6]];
    b = exp_b(ins);
    case (ins[15:12])
      4'h1: return a + b;
      4'h5: return a & b;
      4'h9: return a ^ b;
      default: case (ins[5:4])
        2'b00:   return a << ins[3:0];
        2'b01:   return a >> ins[3:0];
        2'b11:   return 16'($signed(a) >>> ins[3:0]);
        default: return 16'd0;
      endcase
    endcase
  endfunction

  function automatic logic [2:0] exp_op(input logic [15:0] ins);
    case (ins[15:12])
      4'h1: return 3'd0;
      4'h5: return 3'd1;
      4'h9: return 3'd3;
      default: case (ins[5:4])
        2'b00:   return 3'd4;
        2'b01:   return 3'd5;
        2'b11:   return 3'd6;
        default: return 3'd7;
      endcase
    endcase
  endfunction

  function automatic logic [2:0] cc_of(input logic [15:0] r);
    return {r[15], r == 16'd0, !r[15] && r != 16'd0};
  endfunction

  task automatic set_reg(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
    mrf[a] = d;
  endtask

  task automatic run(input logic [15:0] ins);
    logic legal, shf;
    int cyc, we_cnt, exp_lat;
    logic [15:0] res;
    legal   = is_legal(ins[15:12]);
    shf     = (ins[15:12] == 4'hD);
    exp_lat = !legal ? 1 : (shf || ins[5]) ? 3 : 4;
    res     = legal ? model(ins) : 16'd0;
    @(negedge clk);
    chk("ready_before", instr_ready, 1);
    instr_valid = 1'b1; instr = ins;
    @(negedge clk);
    instr_valid = 1'b0; instr = 16'($urandom);
    cyc = 1; we_cnt = 0;
    while (!done && !illegal && cyc < 8) begin
      we_cnt += int'(rf_we);
      @(negedge clk);
      cyc++;
    end
    chk("latency", cyc, exp_lat);
    chk("early_we", we_cnt, 0);
    if (legal) begin
      chk("illegal_lo", illegal, 0);
      chk("we", rf_we, 1);
      chk("waddr", rf_waddr, ins[11:9]);
      chk("wdata", rf_wdata, res);
      chk("alu_op", alu_op, exp_op(ins));
      chk("alu_shift", alu_shift, shf ? ins[3:0] : 4'd0);
      chk("alu_in1", alu_in1, mrf[ins[8:6]]);
      chk("alu_in2", alu_in2, exp_b(ins));
      mrf[ins[11:9]] = res;
      exp_cc = cc_of(res);
    end else begin
      chk("illegal", illegal, 1);
      chk("we_ill", rf_we, 0);
      chk("done_ill", done, 0);
    end
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("illegal_pulse", illegal, 0);
    chk("we_after", rf_we, 0);
    chk("ready_after", instr_ready, 1);
    chk("cc", {cc_n, cc_z, cc_p}, exp_cc);
    chk("rf_dr", rf[ins[11:9]], mrf[ins[11:9]]);
  endtask

  task automatic b2b(input logic [15:0] ins, input int exp_gap);
    int first, second;
    first = -1; second = -1;
    @(negedge clk);
    instr = ins; instr_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (instr_ready) begin
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
      @(negedge clk);
    end
    instr_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("b2b_gap", second - first, exp_gap);
    mrf[ins[11:9]] = model(ins);
    exp_cc = cc_of(mrf[ins[11:9]]);
    chk("b2b_rf", rf[ins[11:9]], mrf[ins[11:9]]);
    chk("b2b_cc", {cc_n, cc_z, cc_p}, exp_cc);
  endtask

  initial begin
    logic [15:0] ins;
    reset_n = 1'b0; instr_valid = 1'b0; instr = 16'd0;
    pl_en = 1'b0; pl_addr = 3'd0; pl_data = 16'd0;
    exp_cc = 3'b010;
    repeat (2) @(negedge clk);
    chk("rst_ready", instr_ready, 1);
    chk("rst_we", rf_we, 0);
    chk("rst_done", done, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_raddr", rf_raddr, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_in1", alu_in1, 0);
    chk("rst_in2", alu_in2, 0);
    chk("rst_op", alu_op, 0);
    chk("rst_shift", alu_shift, 0);
    chk("rst_cc", {cc_n, cc_z, cc_p}, 3'b010);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) set_reg(3'(i), 16'($urandom));

    set_reg(3'd1, 16'h0005); set_reg(3'd2, 16'hFFFB);
    run(16'h1642);
    chk("add_r3", rf[3], 16'h0000);
    chk("add_cc", {cc_n, cc_z, cc_p}, 3'b010);
    set_reg(3'd1, 16'h00F0);
    run(16'h587F);
    chk("and_r4", rf[4], 16'h00F0);
    chk("and_cc", {cc_n, cc_z, cc_p}, 3'b001);
    set_reg(3'd1, 16'h8001);
    run(16'hDA74);
    chk("rshfa_r5", rf[5], 16'hF800);
    chk("rshfa_cc", {cc_n, cc_z, cc_p}, 3'b100);
    run(16'hDA54);
    chk("rshfl_r5", rf[5], 16'h0800);
    chk("rshfl_cc", {cc_n, cc_z, cc_p}, 3'b001);
    set_reg(3'd1, 16'h1234);
    run(16'h947F);
    chk("not_r2", rf[2], 16'hEDCB);
    chk("not_cc", {cc_n, cc_z, cc_p}, 3'b100);
    run(16'h0000);
    chk("br_cc", {cc_n, cc_z, cc_p}, 3'b100);

    // reset during EXEC of ADD R3,R1,R2 with a non-zero sum
    set_reg(3'd1, 16'h0005); set_reg(3'd2, 16'h0001);
    @(negedge clk);
    instr_valid = 1'b1; instr = 16'h1642;
    @(negedge clk);
    instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    exp_cc = 3'b010;
    chk("rx_we", rf_we, 0);
    chk("rx_done", done, 0);
    chk("rx_ready", instr_ready, 1);
    chk("rx_cc", {cc_n, cc_z, cc_p}, exp_cc);
    @(negedge clk);
    chk("rx_we2", rf_we, 0);
    chk("rx_done2", done, 0);
    chk("rx_r3", rf[3], mrf[3]);

    b2b(16'h1642, 5);
    b2b(16'h1661, 4);

    for (int k = 0; k < 40; k++) begin
      if (k % 4 == 0) set_reg(3'($urandom_range(0, 7)), 16'($urandom));
      ins = 16'($urandom);
      if ($urandom_range(0, 5) == 0) ins[15:12] = ill_tab[$urandom_range(0, 11)];
      else ins[15:12] = leg_tab[$urandom_range(0, 3)];
      run(ins);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
